// File: rtl/analog_stim_pkg.sv
// rtl/analog_stim_pkg.sv - shared types and code-to-voltage helper for the analog stimulus driver
package analog_stim_pkg;

  localparam int CODE_W_DEF = 16;
  localparam int STEP_W_DEF = 12;

  typedef enum logic [1:0] {IDLE, RAMP, SETTLE} state_e;

  typedef logic [CODE_W_DEF-1:0] code_t;
  typedef logic [STEP_W_DEF-1:0] step_t;

  // Full scale is 2**code_w codes, so the top code sits one LSB below vref.
  function automatic real code_to_volt(input longint unsigned code, input real vref,
                                       input int code_w);
    real full;
    full = 1.0;
    for (int i = 0; i < code_w; i++) full = full * 2.0;
    return real'(code) * vref / full;
  endfunction

endpackage

// File: rtl/analog_stim_slew.sv
// rtl/analog_stim_slew.sv - combinational next-code step toward target, clamped so it never overshoots
module analog_stim_slew
  import analog_stim_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic [CODE_W-1:0] code,
  input  logic [CODE_W-1:0] target,
  input  logic [STEP_W-1:0] step,
  output logic [CODE_W-1:0] next_code,
  output logic              arrived
);

  logic [CODE_W:0]   code_x;
  logic [CODE_W:0]   target_x;
  logic [CODE_W:0]   step_x;
  logic [CODE_W:0]   diff;
  logic [CODE_W-1:0] step_c;
  logic              up;

  // The move is taken only when diff > step, so code +/- step stays inside the rails.
  always_comb begin
    code_x    = {1'b0, code};
    target_x  = {1'b0, target};
    step_x    = (CODE_W+1)'(step);
    step_c    = CODE_W'(step);
    up        = target_x > code_x;
    diff      = up ? (target_x - code_x) : (code_x - target_x);
    arrived   = (step == '0) || (diff <= step_x);
    next_code = arrived ? target : (up ? (code + step_c) : (code - step_c));
  end

endmodule

// File: rtl/analog_stimulus_driver.sv
// rtl/analog_stimulus_driver.sv - slews a drive code toward commanded targets and publishes it as a real voltage
module analog_stimulus_driver
  import analog_stim_pkg::*;
#(
  parameter int  CODE_W     = CODE_W_DEF,
  parameter int  STEP_W     = STEP_W_DEF,
  parameter int  SETTLE_CYC = 4,
  parameter int  RESET_CODE = 0,
  parameter real VREF       = 1.8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CODE_W-1:0] cmd_target,
  input  logic [STEP_W-1:0] cmd_step,
  input  logic              abort,
  output logic [CODE_W-1:0] code,
  output real               voltage,
  output logic              update_toggle,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] target_q, target_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              toggle_q, toggle_d;
  logic              done_q, done_d;
  logic [CODE_W-1:0] next_code;
  logic              arrived;

  analog_stim_slew #(
    .CODE_W (CODE_W),
    .STEP_W (STEP_W)
  ) u_slew (
    .code      (code_q),
    .target    (target_q),
    .step      (step_q),
    .next_code (next_code),
    .arrived   (arrived)
  );

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    target_d = target_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          target_d = cmd_target;
          step_d   = cmd_step;
          state_d  = RAMP;
        end
      end
      RAMP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          code_d = next_code;
          if (arrived) begin
            cnt_d = '0;
            // With no settle time the done pulse follows arrival directly.
            if (SETTLE_CYC == 0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = SETTLE;
            end
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    toggle_d = toggle_q ^ (code_d != code_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      code_q   <= CODE_W'(RESET_CODE);
      target_q <= CODE_W'(RESET_CODE);
      step_q   <= '0;
      cnt_q    <= '0;
      toggle_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      target_q <= target_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      toggle_q <= toggle_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    cmd_ready     = (state_q == IDLE);
    busy          = (state_q != IDLE);
    done          = done_q;
    code          = code_q;
    update_toggle = toggle_q;
    voltage       = code_to_volt(64'(code_q), VREF, CODE_W);
  end

endmodule

// File: tb/tb_analog_stimulus_driver.sv
// tb/tb_analog_stimulus_driver.sv - directed table-driven bench for analog_stimulus_driver
module tb_analog_stimulus_driver;

  localparam int  CODE_W     = 16;
  localparam int  STEP_W     = 12;
  localparam int  SETTLE_CYC = 4;
  localparam int  RESET_CODE = 100;
  localparam real VREF       = 1.8;
  localparam real LSB        = VREF / 65536.0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CODE_W-1:0] cmd_target;
  logic [STEP_W-1:0] cmd_step;
  logic              abort;
  logic [CODE_W-1:0] code;
  real               voltage;
  logic              update_toggle;
  logic              busy;
  logic              done;

  analog_stimulus_driver #(
    .CODE_W     (CODE_W),
    .STEP_W     (STEP_W),
    .SETTLE_CYC (SETTLE_CYC),
    .RESET_CODE (RESET_CODE),
    .VREF       (VREF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_target    (cmd_target),
    .cmd_step      (cmd_step),
    .abort         (abort),
    .code          (code),
    .voltage       (voltage),
    .update_toggle (update_toggle),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CODE_W-1:0] target;
    logic [STEP_W-1:0] step;
    logic [CODE_W-1:0] exp_first;
    int                exp_ramp;
    int                exp_tog;
  } vec_t;

  vec_t              vecs[10];
  int                checks   = 0;
  int                failures = 0;
  logic [CODE_W-1:0] exp_code;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_volt(input string name, input logic [CODE_W-1:0] exp_c);
    real exp_v;
    exp_v = real'(exp_c) * LSB;
    checks++;
    if ((voltage - exp_v) > 1.0e-9 || (exp_v - voltage) > 1.0e-9) begin
      failures++;
      $display("FAIL %s actual=%f required=%f", name, voltage, exp_v);
    end
  endtask

  task automatic wait_done(input string name, output int edges);
    edges = -1;
    for (int e = 1; e <= 40 && edges < 0; e++) begin
      @(negedge clk);
      if (done) edges = e;
    end
    if (edges < 0) check({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic run_cmd(input logic [CODE_W-1:0] t, input logic [STEP_W-1:0] s,
                         input logic [CODE_W-1:0] first, input int ramp, input int tog,
                         input string tag);
    int   seen_tog;
    int   done_edge;
    logic prev_tog;
    check({tag, "_ready_idle"}, cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_target = t;
    cmd_step   = s;
    prev_tog   = update_toggle;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_ready_busy"}, cmd_ready, 0);
    check({tag, "_code_hold_accept"}, code, exp_code);
    seen_tog  = 0;
    done_edge = -1;
    for (int e = 1; e <= 40 && done_edge < 0; e++) begin
      @(negedge clk);
      if (update_toggle != prev_tog) seen_tog++;
      prev_tog = update_toggle;
      if (e == 1) check({tag, "_first_code"}, code, first);
      if (done) begin
        done_edge = e;
        check({tag, "_ready_at_done"}, cmd_ready, 1);
        check({tag, "_busy_at_done"}, busy, 0);
      end
    end
    check({tag, "_done_edge"}, done_edge, ramp + SETTLE_CYC);
    check({tag, "_final_code"}, code, t);
    check_volt({tag, "_voltage"}, t);
    check({tag, "_toggles"}, seen_tog, tog);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    exp_code = t;
  endtask

  initial begin
    int   edges;
    int   bad;
    logic prev_tog;

    vecs[0] = '{16'd0,     12'd0,    16'd0,     1, 1};
    vecs[1] = '{16'd1000,  12'd300,  16'd300,   4, 4};
    vecs[2] = '{16'd5000,  12'd0,    16'd5000,  1, 1};
    vecs[3] = '{16'd0,     12'd0,    16'd0,     1, 1};
    vecs[4] = '{16'd10,    12'd0,    16'd10,    1, 1};
    vecs[5] = '{16'd0,     12'd4095, 16'd0,     1, 1};
    vecs[6] = '{16'd0,     12'd7,    16'd0,     1, 0};
    vecs[7] = '{16'd60000, 12'd0,    16'd60000, 1, 1};
    vecs[8] = '{16'd65535, 12'd4095, 16'd64095, 2, 2};
    vecs[9] = '{16'd65000, 12'd300,  16'd65235, 2, 2};

    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_target = '0;
    cmd_step   = '0;
    abort      = 1'b0;
    exp_code   = 16'(RESET_CODE);
    repeat (2) @(negedge clk);
    check("rst_code", code, RESET_CODE);
    check_volt("rst_voltage", 16'(RESET_CODE));
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_toggle", update_toggle, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_code", code, RESET_CODE);

    for (int i = 0; i < 10; i++)
      run_cmd(vecs[i].target, vecs[i].step, vecs[i].exp_first, vecs[i].exp_ramp,
              vecs[i].exp_tog, $sformatf("vec%0d", i));

    // Command held valid through busy must not be re-accepted until IDLE.
    cmd_valid  = 1'b1;
    cmd_target = 16'd5000;
    cmd_step   = 12'd0;
    @(negedge clk);
    cmd_target = 16'd7;
    bad   = 0;
    edges = -1;
    for (int e = 1; e <= 40 && edges < 0; e++) begin
      @(negedge clk);
      if (done) edges = e;
      else if (code != 16'd5000 || cmd_ready) bad++;
    end
    check("held_busy_violations", bad, 0);
    check("held_done_edge", edges, 1 + SETTLE_CYC);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("held_reaccept_busy", busy, 1);
    @(negedge clk);
    check("held_reaccept_code", code, 7);
    wait_done("held2", edges);
    @(negedge clk);
    exp_code = 16'd7;

    run_cmd(16'd0, 12'd0, 16'd0, 1, 1, "to_zero");

    // Abort mid-ramp freezes the code with no done.
    cmd_valid  = 1'b1;
    cmd_target = 16'd40000;
    cmd_step   = 12'd1000;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("abort_ramp_c1", code, 1000);
    @(negedge clk);
    check("abort_ramp_c2", code, 2000);
    abort    = 1'b1;
    prev_tog = update_toggle;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ramp_code", code, 2000);
    check("abort_ramp_ready", cmd_ready, 1);
    check("abort_ramp_busy", busy, 0);
    check("abort_ramp_done", done, 0);
    bad = 0;
    repeat (SETTLE_CYC + 3) begin
      @(negedge clk);
      if (done || code != 16'd2000 || update_toggle != prev_tog) bad++;
    end
    check("abort_ramp_quiet", bad, 0);

    // Abort on the terminal SETTLE cycle outranks completion.
    cmd_valid  = 1'b1;
    cmd_target = 16'd2100;
    cmd_step   = 12'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_settle_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_settle_done", done, 0);
    check("abort_settle_ready", cmd_ready, 1);
    check("abort_settle_code", code, 2100);
    @(negedge clk);
    check("abort_settle_done2", done, 0);

    // Abort alone in IDLE does nothing; abort together with a command still accepts.
    abort = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_idle_busy", busy, 0);
    check("abort_idle_code", code, 2100);
    cmd_valid  = 1'b1;
    cmd_target = 16'd2500;
    cmd_step   = 12'd0;
    @(negedge clk);
    abort     = 1'b0;
    cmd_valid = 1'b0;
    check("abort_cmd_accepted", busy, 1);
    @(negedge clk);
    check("abort_cmd_code", code, 2500);
    wait_done("abort_cmd", edges);
    check("abort_cmd_done_edge", edges, SETTLE_CYC);
    @(negedge clk);

    // Asynchronous reset mid-ramp.
    cmd_valid  = 1'b1;
    cmd_target = 16'd40000;
    cmd_step   = 12'd1000;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_code", code, 3500);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_code", code, RESET_CODE);
    check_volt("async_rst_voltage", 16'(RESET_CODE));
    check("async_rst_ready", cmd_ready, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_toggle", update_toggle, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("after_rst_code", code, RESET_CODE);
    check("after_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/analog_stimulus_driver.md
Name: analog_stimulus_driver

Overview:
- Digital-side driver that pushes a real-valued voltage onto an analog node in a mixed-signal simulation.
- It is the write counterpart to the analog probe, which only reads.
- Accepts target/slew commands over a valid/ready handshake and slews an internal code toward the target.
- Publishes the code as a real `voltage`, and flips `update_toggle` on every change so the AMS connect/wreal side can resample.

Parameters:
- CODE_W, 16, width of voltage code (unsigned).
- STEP_W, 12, width of per-cycle slew step.
- SETTLE_CYC, 4, cycles to hold after reaching target before `done` (0 allowed).
- RESET_CODE, 0, code value applied at reset.
- VREF, 1.8 (real), full-scale voltage; LSB = VREF / 2**CODE_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  driver can accept a command
- cmd_target  in  CODE_W  target code
- cmd_step  in  STEP_W  slew step per cycle; 0 = immediate jump
- abort  in  1  freeze output at current code and return to IDLE
- code  out  CODE_W  current drive code
- voltage  out  real  code * LSB, updated in the same cycle as code
- update_toggle  out  1  inverts on every cycle in which code changes
- busy  out  1  high in RAMP or SETTLE
- done  out  1  one-cycle pulse when SETTLE completes

Behaviour:
- Reset (async assert, sync release):
  - code = RESET_CODE; voltage = RESET_CODE*LSB
  - update_toggle = 0, busy = 0, done = 0, cmd_ready = 1
  - state = IDLE
- Reset mid-ramp discards the command immediately.
- States: IDLE, RAMP, SETTLE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, latch target and step, then go to RAMP.
  - cmd_ready = 0 in RAMP and SETTLE; commands are not queued.
- RAMP, one update per cycle, starting the cycle after accept:
  - diff = |target - code|, computed at CODE_W+1 bits with no wrap.
  - If step == 0 or diff <= step: code = target, go to SETTLE.
  - Otherwise code moves by ±step toward target.
  - Never overshoots; never wraps past 0 or 2**CODE_W-1.
- Target equal to current code: RAMP lasts 1 cycle with no code change and no toggle, then SETTLE.
- SETTLE:
  - Counts SETTLE_CYC cycles.
  - On terminal count, done pulses for 1 cycle and state returns to IDLE. cmd_ready rises in that same cycle.
  - SETTLE_CYC = 0: done pulses in the cycle after target is reached.
- Abort:
  - In RAMP or SETTLE: code holds, state goes to IDLE next cycle, done is not pulsed.
  - Abort outranks completion in the same cycle.
  - Ignored in IDLE.
- Simultaneous cmd_valid and abort in IDLE: the command is accepted.
- update_toggle inverts exactly once per code change. voltage and code always agree. done and abort are never both acted on.
- Latency: command accepted at edge N; first code change at edge N+1. A ramp of k steps reaches target at edge N+k; done is high in the cycle after edge N+k+SETTLE_CYC.

Decomposition:
- Package analog_stim_pkg:
  - state_e enum (IDLE, RAMP, SETTLE)
  - code_t / step_t typedefs derived from CODE_W / STEP_W defaults
  - function code_to_volt(code, vref) returning real
- One sub-module, analog_stim_slew: combinational next-code computation (diff, clamp, direction) with an `arrived` flag.
- FSM, settle counter, and toggle/real conversion stay in the top module.

Test Plan:
- Reset with RESET_CODE=100 → code=100, voltage≈100*1.8/65536 V, cmd_ready=1, busy=0; assert rst_n low mid-RAMP → same values at once, asynchronously.
- Command target=1000, step=300 from code 0 → codes 300, 600, 900, 1000 on 4 successive edges; 4 toggles; done 4 cycles later (SETTLE_CYC=4).
- Command target=0, step=0 from code 5000 → code=0 next edge, 1 toggle; done after SETTLE; cmd_valid held during busy not accepted (cmd_ready=0).
- Downward near-rail: code=10, target=0, step=4095 → code=0 in one step, no wrap to 65535.
- Abort in the 2nd RAMP cycle of target=40000 step=1000 from 0 → code holds at 2000, no done, IDLE and cmd_ready=1 next cycle; target equal to current code → no toggle, done after 1+SETTLE_CYC cycles.
